bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit decimal counter. Digits are stored as ASCII characters ("0".."9" = 8'h30..8'h39), so the result goes straight to the LCD/UART text path.
- Generalises the existing increment-only ASCII BCD chain in four ways:
  - configurable digit count;
  - up/down counting;
  - parallel load;
  - wrap or saturate at the range ends, with status flags.
- Sits between event sources (button debouncers, timer ticks) and the text formatter.

Parameters:
- DIGITS, 8: number of decimal digits; legal range 1..16.
- WRAP, 1: 1 = wrap at the range ends; 0 = saturate at the range ends.
- STEP, 1: decimal amount added or subtracted per event; legal range 1..9; applied to digit 0 with full carry/borrow ripple.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- clear, input, 1: synchronous clear to all "0".
- load, input, 1: parallel load of load_val.
- load_val, input, 8*DIGITS: ASCII digits; byte i = digit i; digit 0 at [7:0].
- inc, input, 1: count up by STEP.
- dec, input, 1: count down by STEP.
- result, output, 8*DIGITS: current value as ASCII; byte i = digit i.
- is_zero, output, 1: high while every digit is "0" (registered).
- is_max, output, 1: high while every digit is "9" (registered).
- ovf, output, 1: one-cycle pulse when an increment crosses the top of the range.
- unf, output, 1: one-cycle pulse when a decrement crosses the bottom of the range.
- load_err, output, 1: one-cycle pulse when a load contained a non-digit byte.

Behaviour:
- Reset (rst high at posedge):
  - every result byte = 8'h30;
  - is_zero = 1, is_max = 0;
  - ovf, unf, load_err = 0.
  - rst overrides all other inputs. Asserting rst mid-count discards the count in progress.
- Priority per cycle: rst > clear > load > (inc XOR dec). Only one action takes effect per cycle.
- clear: result = all "0"; ovf/unf/load_err = 0.
- load:
  - each load_val byte in 8'h30..8'h39 is copied unchanged;
  - any other byte is stored as 8'h30;
  - load_err pulses the next cycle if at least one byte was replaced;
  - inc/dec are ignored in a load cycle.
- inc and dec both high, or both low: value unchanged, no pulses.
- Increment:
  - digit 0 += STEP;
  - any digit exceeding "9" subtracts 10 and carries 1 into the next digit;
  - the carry ripples combinationally through all digits within the same cycle;
  - latency 1 clock from input to result.
- Decrement: the same rule with borrow. A digit below "0" adds 10 and borrows from the next digit.
- Top of range (carry out of the MS digit):
  - WRAP = 1: keep the modulo-10^DIGITS result (e.g. 99..99 + 1 -> 00..00); ovf = 1 for one cycle.
  - WRAP = 0: result is forced to all "9"; ovf = 1 for one cycle.
- Bottom of range (borrow out of the MS digit):
  - WRAP = 1: modulo result (00..00 - 1 -> 99..99); unf = 1.
  - WRAP = 0: result forced to all "0"; unf = 1.
- Saturated counter with further same-direction events (WRAP = 0): value stays put, but ovf/unf still pulse for each event.
- ovf, unf and load_err are registered pulses, asserted exactly one cycle after the causing edge. They are never high two cycles in a row unless the cause repeats.
- is_zero and is_max are registered and track the result of the same edge, i.e. they are consistent with result in every cycle.
- No internal state exists beyond the digit registers and the flag registers.

Optional Feature:
- Macro: BCD_LZB_EN.
- Defined:
  - adds output display, 8*DIGITS bits;
  - display equals result, except that leading "0" bytes above the most-significant non-zero digit are replaced by a space (8'h20);
  - digit 0 is never blanked;
  - display is registered and updated on the same edge as result (zero relative latency).
- Undefined: the display port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then one inc (DIGITS=8, WRAP=1, STEP=1) -> result "00000001"; is_zero drops to 0 one cycle after the inc edge.
- Load "00000099", then inc -> "00000100"; a full carry ripple happens in a single cycle with no ovf.
- WRAP=1: load "99999999", inc -> "00000000", ovf pulses 1 cycle. Then dec -> "99999999", unf pulses 1 cycle.
- WRAP=0: load "00000000", dec x3 -> stays "00000000"; unf pulses 3 times; is_zero stays 1.
- Load "12A45678" -> result "12045678"; load_err pulses. Same-cycle inc=1 is ignored. Then inc=dec=1 -> value unchanged, no pulses.
- rst asserted during an inc burst at "00000042" -> "00000000" next edge. With BCD_LZB_EN, load "00000305" -> display "     305".

Source files
------------

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - ASCII BCD up/down counter with load, wrap/saturate and status flags (optional BCD_LZB_EN leading-zero-blanked display)
module bcd_updown_counter #(
    parameter int DIGITS = 8,
    parameter int WRAP   = 1,
    parameter int STEP   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [8*DIGITS-1:0] load_val,
    input  logic                inc,
    input  logic                dec,
    output logic [8*DIGITS-1:0] result,
    output logic                is_zero,
    output logic                is_max,
    output logic                ovf,
    output logic                unf,
`ifdef BCD_LZB_EN
    output logic [8*DIGITS-1:0] display,
`endif
    output logic                load_err
);

    localparam logic [7:0]          ASCII_0  = 8'h30;
    localparam logic [7:0]          ASCII_9  = 8'h39;
    localparam logic [4:0]          STEP5    = 5'(STEP);
    localparam logic [8*DIGITS-1:0] ALL_ZERO = {DIGITS{ASCII_0}};
    localparam logic [8*DIGITS-1:0] ALL_NINE = {DIGITS{ASCII_9}};

    logic [8*DIGITS-1:0] inc_val, dec_val, load_clean, nxt;
    logic                inc_carry, dec_borrow, load_bad;
    logic                nxt_ovf, nxt_unf, nxt_lerr;
    logic [4:0]          d5, addend, sum, dif;
    logic                c, b;
    logic [7:0]          lb;

    // Stored digits are always legal, so the low nibble of each byte is the digit value.
    always_comb begin
        inc_val = '0;
        c       = 1'b0;
        sum     = '0;
        d5      = '0;
        addend  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d5     = {1'b0, result[8*i +: 4]};
            addend = (i == 0) ? STEP5 : {4'b0, c};
            sum    = d5 + addend;
            if (sum > 5'd9) begin
                sum = sum - 5'd10;
                c   = 1'b1;
            end else begin
                c   = 1'b0;
            end
            inc_val[8*i +: 8] = {4'h3, sum[3:0]};
        end
        inc_carry = c;
    end

    always_comb begin
        dec_val = '0;
        b       = 1'b0;
        dif     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, result[8*i +: 4]} < ((i == 0) ? STEP5 : {4'b0, b})) begin
                dif = {1'b0, result[8*i +: 4]} + 5'd10 - ((i == 0) ? STEP5 : {4'b0, b});
                b   = 1'b1;
            end else begin
                dif = {1'b0, result[8*i +: 4]} - ((i == 0) ? STEP5 : {4'b0, b});
                b   = 1'b0;
            end
            dec_val[8*i +: 8] = {4'h3, dif[3:0]};
        end
        dec_borrow = b;
    end

    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        lb         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lb = load_val[8*i +: 8];
            if (lb >= ASCII_0 && lb <= ASCII_9) begin
                load_clean[8*i +: 8] = lb;
            end else begin
                load_clean[8*i +: 8] = ASCII_0;
                load_bad             = 1'b1;
            end
        end
    end

    always_comb begin
        nxt      = result;
        nxt_ovf  = 1'b0;
        nxt_unf  = 1'b0;
        nxt_lerr = 1'b0;
        if (clear) begin
            nxt = ALL_ZERO;
        end else if (load) begin
            nxt      = load_clean;
            nxt_lerr = load_bad;
        end else if (inc && !dec) begin
            nxt     = (inc_carry && WRAP == 0) ? ALL_NINE : inc_val;
            nxt_ovf = inc_carry;
        end else if (dec && !inc) begin
            nxt     = (dec_borrow && WRAP == 0) ? ALL_ZERO : dec_val;
            nxt_unf = dec_borrow;
        end
    end

`ifdef BCD_LZB_EN
    logic [8*DIGITS-1:0] nxt_disp;
    logic                seen_nz;

    // Blank from the top down until the first non-zero digit; digit 0 always shows.
    always_comb begin
        nxt_disp       = nxt;
        seen_nz        = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (nxt[8*i +: 8] != ASCII_0) seen_nz = 1'b1;
            if (!seen_nz) nxt_disp[8*i +: 8] = 8'h20;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) display <= {{(DIGITS-1){8'h20}}, ASCII_0};
        else     display <= nxt_disp;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= ALL_ZERO;
            is_zero  <= 1'b1;
            is_max   <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            result   <= nxt;
            is_zero  <= (nxt == ALL_ZERO);
            is_max   <= (nxt == ALL_NINE);
            ovf      <= nxt_ovf;
            unf      <= nxt_unf;
            load_err <= nxt_lerr;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - bench for bcd_updown_counter, wrapping (STEP 1) and saturating (STEP 3) instances
module tb_bcd_updown_counter;

    localparam longint MODV = 64'd100000000;
    localparam int     STEP_W = 1;
    localparam int     STEP_S = 3;

    logic        clk = 1'b0;
    logic        rst, clear, load, inc, dec;
    logic [63:0] load_val;

    logic [63:0] res_w, res_s;
    logic        z_w, m_w, o_w, u_w, e_w;
    logic        z_s, m_s, o_s, u_s, e_s;
`ifdef BCD_LZB_EN
    logic [63:0] disp_w, disp_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    longint mv [2];
    logic   mo [2];
    logic   mu [2];
    logic   me [2];

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(8), .WRAP(1), .STEP(STEP_W)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .result(res_w), .is_zero(z_w), .is_max(m_w),
        .ovf(o_w), .unf(u_w),
`ifdef BCD_LZB_EN
        .display(disp_w),
`endif
        .load_err(e_w));

    bcd_updown_counter #(.DIGITS(8), .WRAP(0), .STEP(STEP_S)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .result(res_s), .is_zero(z_s), .is_max(m_s),
        .ovf(o_s), .unf(u_s),
`ifdef BCD_LZB_EN
        .display(disp_s),
`endif
        .load_err(e_s));

    function automatic logic [63:0] to_ascii(input longint v);
        logic [63:0] r;
        longint      t;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = 8'h30 + 8'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] to_display(input longint v);
        logic [63:0] r;
        int          nd;
        longint      t;
        r  = to_ascii(v);
        nd = 1;
        t  = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        for (int i = nd; i < 8; i++) r[8*i +: 8] = 8'h20;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, input int wrap, input int stp);
        longint v;
        logic [7:0] bt;
        mo[k] = 1'b0; mu[k] = 1'b0; me[k] = 1'b0;
        if (rst || clear) begin
            mv[k] = 0;
        end else if (load) begin
            v = 0;
            for (int i = 7; i >= 0; i--) begin
                bt = load_val[8*i +: 8];
                if (bt >= 8'h30 && bt <= 8'h39) v = v * 10 + longint'(bt - 8'h30);
                else begin
                    v = v * 10;
                    me[k] = 1'b1;
                end
            end
            mv[k] = v;
        end else if (inc && !dec) begin
            v = mv[k] + stp;
            if (v >= MODV) begin
                mo[k] = 1'b1;
                v = (wrap != 0) ? v - MODV : MODV - 1;
            end
            mv[k] = v;
        end else if (dec && !inc) begin
            v = mv[k] - stp;
            if (v < 0) begin
                mu[k] = 1'b1;
                v = (wrap != 0) ? v + MODV : 0;
            end
            mv[k] = v;
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic l,
                         input logic [63:0] lv, input logic i, input logic d);
        rst = r; clear = c; load = l; load_val = lv; inc = i; dec = d;
        @(posedge clk);
        model(0, 1, STEP_W);
        model(1, 0, STEP_S);
        #1;
        check("w_result", res_w, to_ascii(mv[0]));
        check("w_zero", 64'(z_w), 64'(mv[0] == 0));
        check("w_max", 64'(m_w), 64'(mv[0] == MODV - 1));
        check("w_ovf", 64'(o_w), 64'(mo[0]));
        check("w_unf", 64'(u_w), 64'(mu[0]));
        check("w_lerr", 64'(e_w), 64'(me[0]));
        check("s_result", res_s, to_ascii(mv[1]));
        check("s_zero", 64'(z_s), 64'(mv[1] == 0));
        check("s_max", 64'(m_s), 64'(mv[1] == MODV - 1));
        check("s_ovf", 64'(o_s), 64'(mo[1]));
        check("s_unf", 64'(u_s), 64'(mu[1]));
        check("s_lerr", 64'(e_s), 64'(me[1]));
`ifdef BCD_LZB_EN
        check("w_display", disp_w, to_display(mv[0]));
        check("s_display", disp_s, to_display(mv[1]));
`endif
    endtask

    function automatic logic [63:0] rand_load();
        logic [63:0] v;
        int          sel;
        sel = $urandom_range(0, 9);
        if (sel < 3)      v = to_ascii(MODV - 1 - longint'($urandom_range(0, 5)));
        else if (sel < 6) v = to_ascii(longint'($urandom_range(0, 5)));
        else              v = to_ascii(longint'($urandom_range(0, 99999999)));
        if ($urandom_range(0, 4) == 0) v[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
        return v;
    endfunction

    initial begin
        int op;
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; inc = 1'b0; dec = 1'b0;
        mv[0] = 0; mv[1] = 0;

        cycle(1, 0, 0, '0, 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 1, "00000099", 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 1, "99999999", 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 0, '0, 0, 1);
        cycle(0, 0, 0, '0, 0, 0);
        cycle(0, 0, 1, "00000000", 0, 0);
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, '0, 0, 1);
        cycle(0, 0, 1, "99999999", 0, 0);
        for (int n = 0; n < 2; n++) cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 1, "12A45678", 1, 0);
        cycle(0, 0, 0, '0, 1, 1);
        cycle(0, 0, 0, '0, 0, 0);
        cycle(0, 0, 1, "00000042", 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(1, 0, 0, '0, 1, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 1, "00000305", 0, 0);
        cycle(0, 1, 1, "77777777", 1, 0);

        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 99);
            if (op < 2)       cycle(1, $urandom_range(0, 1) == 1, 1'b0, '0, 1'b1, 1'b0);
            else if (op < 5)  cycle(0, 1, $urandom_range(0, 1) == 1, rand_load(), 1'b0, 1'b1);
            else if (op < 15) cycle(0, 0, 1, rand_load(), $urandom_range(0, 1) == 1, 1'b0);
            else              cycle(0, 0, 0, '0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
